inst_fetch: RTL and testbench

- Fetch stage of the pipelined 32-bit MIPS core.
- Consumes the redirect target and stall signal produced by the next-PC logic. Issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to decode.
- Discards in-flight responses made stale by a branch/jump redirect.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/inst_fetch_if.sv | 13 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/inst_fetch.sv | 110 +++++++++++
 tb/tb_inst_fetch.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: widths, reset vector,
// fetch FSM encoding and the prefetch FIFO entry layout.
package cpu_pkg;
   localparam int          INST_W       = 32;
   localparam logic [31:0] PC_INC       = 32'd4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP          = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory read port: req/gnt address phase, in-order rvalid data phase.
interface inst_fetch_if;
   import cpu_pkg::*;

   logic              req;
   logic [31:0]       addr;
   logic              gnt;
   logic              rvalid;
   logic [INST_W-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the prefetch buffer and the PC tag queue.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);
   localparam int             PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: issues word reads, tags responses with their PC, buffers them for
// decode and drops responses made stale by a redirect.
//
//   state | meaning
//   FETCH | no stale responses in flight; every response is kept
//   DRAIN | discard > 0; next responses are dropped, new requests may still issue
module inst_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2,
   parameter int          CNT_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              loaddepend,
   inst_fetch_if.master      imem,
   output logic              if_valid,
   output logic [INST_W-1:0] if_inst,
   output logic [31:0]       if_pc
);
   localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

   fetch_state_t     state;
   logic [31:0]      fetch_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] stale_left;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] tag_count;
   logic [CNT_W:0]   budget;
   logic [31:0]      tag_head;
   fetch_entry_t     fifo_din;
   fetch_entry_t     fifo_head;
   logic             grant;
   logic             rsp;
   logic             rsp_keep;
   logic             pop;

   // Reserving FIFO space at request time is what keeps the FIFO from overflowing.
   assign budget     = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem.req   = rst_n && !redirect && (budget < DEPTH_W);
   assign imem.addr  = fetch_pc;
   assign grant      = imem.req && imem.gnt;
   assign rsp        = imem.rvalid && (outstanding != '0);
   assign rsp_keep   = imem.rvalid && (discard == '0) && (tag_count != '0) && !redirect;
   assign stale_left = outstanding - CNT_W'(rsp);

   assign if_valid = (fifo_count != '0);
   assign pop      = if_valid && !loaddepend && !redirect;
   assign if_pc    = if_valid ? fifo_head.pc   : 32'h0;
   assign if_inst  = if_valid ? fifo_head.inst : NOP;
   assign fifo_din = '{pc: tag_head, inst: imem.rdata};

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (grant),
      .pop   (rsp_keep),
      .flush (redirect),
      .din   (fetch_pc),
      .count (tag_count),
      .head  (tag_head)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t)), .CNT_W(CNT_W)) u_inst_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_keep),
      .pop   (pop),
      .flush (redirect),
      .din   (fifo_din),
      .count (fifo_count),
      .head  (fifo_head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp);
         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc <= redirect_pc;
            discard  <= stale_left;
            state    <= (stale_left != '0) ? DRAIN : FETCH;
         end else begin
            if (grant) fetch_pc <= fetch_pc + PC_INC;
            case (state)
               FETCH: discard <= '0;
               DRAIN: begin
                  if (rsp) begin
                     discard <= discard - CNT_W'(1);
                     if (discard == CNT_W'(1)) state <= FETCH;
                  end
               end
               default: begin
                  state   <= FETCH;
                  discard <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic, checked every cycle
// against an epoch-tagged queue model of fetch, memory and the decode buffer.
module tb_inst_fetch;
   import cpu_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic        loaddepend = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;

   inst_fetch_if imem();

   inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH), .CNT_W(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .loaddepend  (loaddepend),
      .imem        (imem),
      .if_valid    (if_valid),
      .if_inst     (if_inst),
      .if_pc       (if_pc)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; int ep; } flight_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } item_t;

   flight_t     infl[$];
   item_t       q[$];
   int          epoch = 0;
   logic [31:0] m_pc  = RPC;
   int          total = 0;
   int          bad   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input logic exp_req);
      chk("req", 32'(imem.req), 32'(exp_req));
      chk("addr", imem.addr, m_pc);
      chk("if_valid", 32'(if_valid), 32'(q.size() > 0));
      chk("if_pc", if_pc, (q.size() > 0) ? q[0].pc : 32'h0);
      chk("if_inst", if_inst, (q.size() > 0) ? q[0].inst : 32'h0);
   endtask

   // One clock: drive at negedge, check settled outputs, then advance the model at posedge.
   task automatic step(input logic rd, input logic [31:0] rpc, input logic ld,
                       input int gnt_pct, input int rv_pct);
      logic    rv, exp_req, grant, pop_ok;
      flight_t f;
      item_t   it;
      @(negedge clk);
      redirect    = rd;
      redirect_pc = rpc;
      loaddepend  = ld;
      imem.gnt    = ($urandom_range(99) < gnt_pct);
      rv          = (infl.size() > 0) && ($urandom_range(99) < rv_pct);
      imem.rvalid = rv;
      imem.rdata  = rv ? mem_word(infl[0].pc) : $urandom;
      #1;
      exp_req = !rd && ((infl.size() + q.size()) < DEPTH);
      chk_outputs(exp_req);
      @(posedge clk);
      grant  = exp_req && imem.gnt;
      pop_ok = (q.size() > 0) && !ld && !rd;
      if (pop_ok) void'(q.pop_front());
      if (rv) begin
         f = infl.pop_front();
         if (f.ep == epoch && !rd) begin
            it.pc   = f.pc;
            it.inst = mem_word(f.pc);
            q.push_back(it);
         end
      end
      if (grant) begin
         f.pc = m_pc;
         f.ep = epoch;
         infl.push_back(f);
         m_pc = m_pc + 32'd4;
      end
      if (rd) begin
         epoch++;
         q.delete();
         m_pc = rpc;
      end
   endtask

   task automatic model_reset();
      infl.delete();
      q.delete();
      epoch++;
      m_pc = RPC;
   endtask

   initial begin
      imem.gnt    = 1'b0;
      imem.rvalid = 1'b0;
      imem.rdata  = 32'h0;
      #1;
      chk_outputs(1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // free run with a 1-cycle memory
      repeat (8) step(1'b0, 32'h0, 1'b0, 100, 100);
      // decode stall: output freezes, buffer fills, requests stop
      repeat (5) step(1'b0, 32'h0, 1'b1, 100, 100);
      repeat (6) step(1'b0, 32'h0, 1'b0, 100, 100);

      // two requests in flight at 0x10/0x14, then redirect away
      step(1'b1, 32'h10, 1'b0, 0, 0);
      repeat (2) step(1'b0, 32'h0, 1'b0, 100, 0);
      step(1'b1, 32'h200, 1'b0, 0, 0);
      repeat (8) step(1'b0, 32'h0, 1'b0, 100, 100);

      // redirect coincident with the 0x14 response
      step(1'b1, 32'h10, 1'b0, 0, 0);
      repeat (2) step(1'b0, 32'h0, 1'b1, 100, 0);
      step(1'b0, 32'h0, 1'b1, 0, 100);
      step(1'b1, 32'h300, 1'b0, 0, 100);
      repeat (6) step(1'b0, 32'h0, 1'b0, 100, 100);

      // stale responses still draining while the new path already issues
      step(1'b1, 32'h40, 1'b0, 0, 0);
      repeat (2) step(1'b0, 32'h0, 1'b1, 100, 0);
      step(1'b1, 32'h80, 1'b0, 0, 0);
      step(1'b1, 32'h90, 1'b0, 0, 0);
      repeat (8) step(1'b0, 32'h0, 1'b0, 100, 50);

      // grant withheld: address must stay put
      step(1'b1, 32'h8, 1'b0, 0, 100);
      repeat (3) step(1'b0, 32'h0, 1'b0, 0, 100);
      repeat (4) step(1'b0, 32'h0, 1'b0, 100, 100);

      // misaligned target and 32-bit wrap
      step(1'b1, 32'hFFFF_FFF9, 1'b0, 0, 100);
      repeat (8) step(1'b0, 32'h0, 1'b0, 100, 100);

      // reset mid-burst with one response pending
      step(1'b1, 32'h40, 1'b0, 0, 0);
      step(1'b0, 32'h0, 1'b0, 100, 0);
      @(negedge clk);
      redirect    = 1'b0;
      imem.gnt    = 1'b0;
      imem.rvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_outputs(1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      imem.rvalid = 1'b1;
      imem.rdata  = 32'hDEAD_BEEF;
      #1;
      chk_outputs(1'b1);
      @(posedge clk);
      repeat (6) step(1'b0, 32'h0, 1'b0, 100, 100);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic        rd;
         logic [31:0] tgt;
         rd  = ($urandom_range(99) < 6);
         tgt = {$urandom_range(255), 2'b00} << 2;
         step(rd, tgt, ($urandom_range(99) < 30), 60, 50);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
